// File: rtl/mat_vec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mat_vec_pkg                                           |
// | Purpose  : Shared state encoding and sizing constants for the    |
// |            matrix-vector engine.                                 |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package mat_vec_pkg;

  // Width of the runtime dimension input and of the row/column counters.
  localparam int DIM_W           = 5;
  localparam int DEFAULT_MAX_DIM = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_VEC = 3'd1,
    RD_MAT   = 3'd2,
    WR_RES   = 3'd3,
    FIN      = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mat_vec_mac.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mat_vec_mac                                           |
// | Purpose  : Multiply-accumulate with truncated product and        |
// |            modulo-2^DATA_W accumulator.                          |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module mat_vec_mac #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_prod;

  // Only the low DATA_W bits of the product matter, which makes the
  // result identical for signed and unsigned operands.
  assign w_prod = a * b;
  assign acc    = r_acc;

  // Accumulator: clear has priority over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mat_vec_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mat_vec_engine                                        |
// | Purpose  : res = mat * vec over a single-port word memory with   |
// |            a req/ack handshake; vec is buffered once per run.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module mat_vec_engine
  import mat_vec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MAX_DIM = DEFAULT_MAX_DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim,
  input  logic [ADDR_W-1:0] matBase,
  input  logic [ADDR_W-1:0] vecBase,
  input  logic [ADDR_W-1:0] resBase,
  output logic              memReq,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int               c_IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int               c_BUF_N   = 1 << c_IDX_W;
  localparam logic [DIM_W-1:0] c_MAX_DIM = DIM_W'(MAX_DIM);

  state_t              r_state, w_next;
  logic [DIM_W-1:0]    r_n, r_i, r_j;
  logic [ADDR_W-1:0]   r_mat_addr, r_vec_base, r_res_base;
  logic                r_err;
  logic [DATA_W-1:0]   r_vbuf [c_BUF_N];
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_dim_ok, w_last_j, w_last_i, w_mac_en, w_mac_clr;
  logic [DATA_W-1:0]   w_acc;

  assign w_dim_ok = (dim != '0) && (dim <= c_MAX_DIM);
  assign w_last_j = (r_j == r_n - DIM_W'(1));
  assign w_last_i = (r_i == r_n - DIM_W'(1));
  assign w_idx    = r_j[c_IDX_W-1:0];

  mat_vec_mac #(.DATA_W(DATA_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_mac_clr),
    .en    (w_mac_en),
    .a     (memRData),
    .b     (r_vbuf[w_idx]),
    .acc   (w_acc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and bus outputs; request fields depend only on registered
  // state, so they hold steady until the ack cycle.
  always_comb begin
    w_next    = r_state;
    memReq    = 1'b0;
    memWrite  = 1'b0;
    memAddr   = '0;
    memWData  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    w_mac_en  = 1'b0;
    w_mac_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = w_dim_ok ? LOAD_VEC : FIN;
      end
      LOAD_VEC: begin
        memReq  = 1'b1;
        memAddr = r_vec_base + ADDR_W'(r_j);
        if (memAck && w_last_j) w_next = RD_MAT;
      end
      RD_MAT: begin
        memReq   = 1'b1;
        memAddr  = r_mat_addr;
        w_mac_en = memAck;
        if (memAck && w_last_j) w_next = WR_RES;
      end
      WR_RES: begin
        memReq    = 1'b1;
        memWrite  = 1'b1;
        memAddr   = r_res_base + ADDR_W'(r_i);
        memWData  = w_acc;
        w_mac_clr = memAck;
        if (memAck) w_next = w_last_i ? FIN : RD_MAT;
      end
      FIN: begin
        done   = 1'b1;
        error  = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Run parameters, counters and the running row-major matrix address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_mat_addr <= '0;
      r_vec_base <= '0;
      r_res_base <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (start) begin
          r_n        <= dim;
          r_i        <= '0;
          r_j        <= '0;
          r_mat_addr <= matBase;
          r_vec_base <= vecBase;
          r_res_base <= resBase;
          r_err      <= !w_dim_ok;
        end
        LOAD_VEC: if (memAck) r_j <= w_last_j ? '0 : r_j + DIM_W'(1);
        RD_MAT: if (memAck) begin
          r_mat_addr <= r_mat_addr + ADDR_W'(1);
          r_j        <= w_last_j ? '0 : r_j + DIM_W'(1);
        end
        WR_RES: if (memAck) r_i <= r_i + DIM_W'(1);
        FIN:    r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  // Vector buffer fill; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (r_state == LOAD_VEC && memAck) r_vbuf[w_idx] <= memRData;
  end

endmodule
`default_nettype wire
